// File: rtl/sky_stacker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sky_stacker_pkg
//  Description : Shared types and constants for the tower-stacking game:
//                tracker state encoding, block colours, score increments and
//                a saturating score adder.
//  Revision    : 1.0 - initial release
// ============================================================================
package sky_stacker_pkg;

    // Tracker states
    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_CATCH = 2'd1,
        ST_CLEAR = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    // Block colours; NONE marks an empty tower slot
    localparam logic [1:0] c_color_none = 2'd0;
    localparam logic [1:0] c_color_c1   = 2'd1;
    localparam logic [1:0] c_color_c2   = 2'd2;
    localparam logic [1:0] c_color_c3   = 2'd3;

    // Score increments
    localparam logic [15:0] c_score_catch = 16'd1;
    localparam logic [15:0] c_score_match = 16'd5;

    // Bonus for filling the whole tower: two points per block of capacity
    function automatic logic [15:0] score_clear(input int max_stack);
        return 16'(2 * max_stack);
    endfunction

    // Score never wraps; it pins at all-ones
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/stack_tracker_color_stack.sv
`default_nettype none
// ============================================================================
//  Module      : color_stack
//  Description : 2-bit colour LIFO of depth MAX_STACK. Supports push, a
//                double pop (top two entries) and a full clear. Exposes the
//                height, the top colour, the packed contents (entry 0 =
//                bottom, unused slots read 0) and a flag telling whether the
//                top two entries both equal a candidate colour.
//  Revision    : 1.0 - initial release
// ============================================================================
module color_stack
    import sky_stacker_pkg::*;
#(
    parameter int MAX_STACK = 8,
    parameter bit MATCH_EN  = 1'b0
) (
    input  logic                   fall_clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop2,
    input  logic                   clear,
    input  logic [1:0]             push_color,
    input  logic [1:0]             match_color,
    output logic [3:0]             height,
    output logic [1:0]             top,
    output logic [2*MAX_STACK-1:0] contents,
    output logic                   top2_match
);

    localparam logic [3:0] c_depth = 4'(MAX_STACK);

    logic [1:0] r_mem [MAX_STACK];
    logic [3:0] r_height;
    logic [1:0] w_top;
    logic [1:0] w_second;

    // Storage update: clear wins, then push (when not full), then double pop
    always_ff @(posedge fall_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_STACK; i++) r_mem[i] <= c_color_none;
            r_height <= 4'd0;
        end else if (clear) begin
            for (int i = 0; i < MAX_STACK; i++) r_mem[i] <= c_color_none;
            r_height <= 4'd0;
        end else if (push && (r_height < c_depth)) begin
            for (int i = 0; i < MAX_STACK; i++) begin
                if (r_height == 4'(i)) r_mem[i] <= push_color;
            end
            r_height <= r_height + 4'd1;
        end else if (pop2 && (r_height >= 4'd2)) begin
            // Popped slots are zeroed so unused entries always read NONE
            for (int i = 0; i < MAX_STACK; i++) begin
                if ((r_height == 4'(i + 1)) || (r_height == 4'(i + 2))) r_mem[i] <= c_color_none;
            end
            r_height <= r_height - 4'd2;
        end
    end

    // Select the top and second-from-top entries from the current height
    always_comb begin
        w_top    = c_color_none;
        w_second = c_color_none;
        for (int i = 0; i < MAX_STACK; i++) begin
            if (r_height == 4'(i + 1)) w_top    = r_mem[i];
            if (r_height == 4'(i + 2)) w_second = r_mem[i];
        end
    end

    generate
        for (genvar i = 0; i < MAX_STACK; i++) begin : g_pack
            assign contents[2*i +: 2] = r_mem[i];
        end
    endgenerate

    assign height     = r_height;
    assign top        = w_top;
    assign top2_match = MATCH_EN && (r_height >= 4'd2) &&
                        (w_top == match_color) && (w_second == match_color);

endmodule
`default_nettype wire

// File: rtl/stack_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : stack_tracker
//  Description : Compares the falling item against the catcher and the
//                current tower top every fall_clk, decides catch or miss,
//                keeps the colour tower, score and miss count, and pulses
//                collision for one cycle on every catch so the item respawns.
//  Options     : SKY_STACKER_COLOR_MATCH_EN - when defined, catching a block
//                whose colour equals the top two tower blocks removes those
//                two blocks and scores 5 instead of pushing.
//  Revision    : 1.0 - initial release
// ============================================================================
module stack_tracker
    import sky_stacker_pkg::*;
#(
    parameter int ITEM_W     = 20,
    parameter int ITEM_H     = 20,
    parameter int CATCH_W    = 80,
    parameter int BASE_Y     = 460,
    parameter int MISS_Y     = 400,
    parameter int MAX_STACK  = 8,
    parameter int MISS_LIMIT = 3
) (
    input  logic                   fall_clk,
    input  logic                   rst,
    input  logic                   pause,
    input  logic [9:0]             item_x,
    input  logic [9:0]             item_y,
    input  logic [1:0]             item_color,
    input  logic [9:0]             catcher_x,
    output logic                   collision,
    output logic [3:0]             stack_height,
    output logic [1:0]             top_color,
    output logic [2*MAX_STACK-1:0] stack_colors,
    output logic [15:0]            score,
    output logic [1:0]             misses,
    output logic                   game_over
);

`ifdef SKY_STACKER_COLOR_MATCH_EN
    localparam bit c_match_en = 1'b1;
`else
    localparam bit c_match_en = 1'b0;
`endif

    localparam logic [10:0] c_item_w     = 11'(ITEM_W);
    localparam logic [10:0] c_item_h     = 11'(ITEM_H);
    localparam logic [10:0] c_catch_w    = 11'(CATCH_W);
    localparam logic [10:0] c_base_y     = 11'(BASE_Y);
    localparam logic [10:0] c_miss_y     = 11'(MISS_Y);
    localparam logic [3:0]  c_max_stack  = 4'(MAX_STACK);
    localparam logic [1:0]  c_miss_limit = 2'(MISS_LIMIT);
    localparam logic [15:0] c_score_full = score_clear(MAX_STACK);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_score;
    logic [15:0] w_score_nxt;
    logic [1:0]  r_misses;
    logic [1:0]  w_misses_nxt;
    logic [1:0]  w_misses_inc;
    logic        r_armed;
    logic        w_armed_nxt;

    logic        w_push;
    logic        w_pop2;
    logic        w_clear;
    logic        w_match;

    logic [10:0] w_top_y;
    logic [10:0] w_item_x;
    logic [10:0] w_item_y;
    logic [10:0] w_catcher_x;
    logic        w_hit_y;
    logic        w_overlap;
    logic        w_past_miss;

    color_stack #(
        .MAX_STACK (MAX_STACK),
        .MATCH_EN  (c_match_en)
    ) u_color_stack (
        .fall_clk    (fall_clk),
        .rst         (rst),
        .push        (w_push),
        .pop2        (w_pop2),
        .clear       (w_clear),
        .push_color  (item_color),
        .match_color (item_color),
        .height      (stack_height),
        .top         (top_color),
        .contents    (stack_colors),
        .top2_match  (w_match)
    );

    // Geometry in 11-bit unsigned so item_y + ITEM_H cannot wrap
    assign w_item_x    = {1'b0, item_x};
    assign w_item_y    = {1'b0, item_y};
    assign w_catcher_x = {1'b0, catcher_x};
    assign w_top_y     = c_base_y - (c_item_h * {7'd0, stack_height});
    assign w_hit_y     = (w_item_y + c_item_h) >= w_top_y;
    assign w_overlap   = ((w_item_x + c_item_w) > w_catcher_x) &&
                         (w_item_x < (w_catcher_x + c_catch_w));
    assign w_past_miss = w_item_y >= c_miss_y;
    assign w_misses_inc = (r_misses >= c_miss_limit) ? c_miss_limit : (r_misses + 2'd1);

    // Next-state, counter and tower-control decisions
    always_comb begin
        w_state_nxt  = r_state;
        w_score_nxt  = r_score;
        w_misses_nxt = r_misses;
        w_armed_nxt  = r_armed;
        w_push       = 1'b0;
        w_pop2       = 1'b0;
        w_clear      = 1'b0;

        // A fresh spawn at the top of the screen re-arms evaluation
        if (item_y == 10'd0) w_armed_nxt = 1'b1;

        case (r_state)
            ST_PLAY: begin
                if (!pause && r_armed) begin
                    if (w_hit_y && w_overlap) begin
                        w_armed_nxt = 1'b0;
                        w_state_nxt = ST_CATCH;
                        if (w_match) begin
                            w_pop2      = 1'b1;
                            w_score_nxt = sat_add16(r_score, c_score_match);
                        end else begin
                            w_push      = 1'b1;
                            w_score_nxt = sat_add16(r_score, c_score_catch);
                        end
                    end else if (w_hit_y || w_past_miss) begin
                        w_armed_nxt  = 1'b0;
                        w_misses_nxt = w_misses_inc;
                        if (w_misses_inc == c_miss_limit) w_state_nxt = ST_OVER;
                    end
                end
            end
            ST_CATCH: begin
                // A full tower is cleared on entry to CLEAR and pays the bonus
                if (stack_height == c_max_stack) begin
                    w_clear     = 1'b1;
                    w_score_nxt = sat_add16(r_score, c_score_full);
                    w_state_nxt = ST_CLEAR;
                end else begin
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_CLEAR: begin
                w_state_nxt = ST_PLAY;
            end
            ST_OVER: begin
                w_armed_nxt = r_armed;
            end
            default: begin
                w_state_nxt = ST_PLAY;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge fall_clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_PLAY;
            r_score  <= 16'd0;
            r_misses <= 2'd0;
            r_armed  <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_score  <= w_score_nxt;
            r_misses <= w_misses_nxt;
            r_armed  <= w_armed_nxt;
        end
    end

    assign collision = (r_state == ST_CATCH);
    assign game_over = (r_state == ST_OVER);
    assign score     = r_score;
    assign misses    = r_misses;

endmodule
`default_nettype wire

// File: tb/tb_stack_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stack_tracker
//  Description : Directed self-checking bench for stack_tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_tracker;

    logic        fall_clk;
    logic        rst;
    logic        pause;
    logic [9:0]  item_x;
    logic [9:0]  item_y;
    logic [1:0]  item_color;
    logic [9:0]  catcher_x;
    logic        collision;
    logic [3:0]  stack_height;
    logic [1:0]  top_color;
    logic [15:0] stack_colors;
    logic [15:0] score;
    logic [1:0]  misses;
    logic        game_over;

    int errors = 0;
    int checks = 0;

    stack_tracker dut (
        .fall_clk     (fall_clk),
        .rst          (rst),
        .pause        (pause),
        .item_x       (item_x),
        .item_y       (item_y),
        .item_color   (item_color),
        .catcher_x    (catcher_x),
        .collision    (collision),
        .stack_height (stack_height),
        .top_color    (top_color),
        .stack_colors (stack_colors),
        .score        (score),
        .misses       (misses),
        .game_over    (game_over)
    );

    initial fall_clk = 1'b0;
    always #5 fall_clk = ~fall_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Advance one edge and sample 1 time unit later
    task automatic tick();
        @(posedge fall_clk);
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic apply_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    // Spawn an item (y=0) then drop it straight onto the landing row (y=440)
    task automatic drop(input logic [9:0] x, input logic [9:0] cx, input logic [1:0] col);
        item_x     = x;
        catcher_x  = cx;
        item_color = col;
        item_y     = 10'd0;
        tick();
        item_y     = 10'd440;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++; if (collision !== 1'b0) begin errors++; $display("FAIL reset_collision: got %0d want 0", collision); end
        checks++; if (stack_height !== 4'd0) begin errors++; $display("FAIL reset_height: got %0d want 0", stack_height); end
        checks++; if (top_color !== 2'd0) begin errors++; $display("FAIL reset_top: got %0d want 0", top_color); end
        checks++; if (stack_colors !== 16'h0) begin errors++; $display("FAIL reset_colors: got %h want 0000", stack_colors); end
        checks++; if (score !== 16'd0) begin errors++; $display("FAIL reset_score: got %0d want 0", score); end
        checks++; if (misses !== 2'd0) begin errors++; $display("FAIL reset_misses: got %0d want 0", misses); end
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_over: got %0d want 0", game_over); end
        rst = 1'b0;
    endtask

    task automatic test_catch();
        logic [9:0] ys [4];
        ys = '{10'd0, 10'd100, 10'd200, 10'd300};
        apply_reset();
        item_x = 10'd110; catcher_x = 10'd100; item_color = 2'd1;
        foreach (ys[i]) begin
            item_y = ys[i];
            tick();
            checks++; if (collision !== 1'b0) begin errors++; $display("FAIL catch_early_y%0d: got %0d want 0", ys[i], collision); end
        end
        item_y = 10'd440;
        tick();
        checks++; if (collision !== 1'b1) begin errors++; $display("FAIL catch_pulse: got %0d want 1", collision); end
        checks++; if (stack_height !== 4'd1) begin errors++; $display("FAIL catch_height: got %0d want 1", stack_height); end
        checks++; if (score !== 16'd1) begin errors++; $display("FAIL catch_score: got %0d want 1", score); end
        checks++; if (top_color !== 2'd1) begin errors++; $display("FAIL catch_top: got %0d want 1", top_color); end
        checks++; if (stack_colors !== 16'h0001) begin errors++; $display("FAIL catch_colors: got %h want 0001", stack_colors); end
        item_y = 10'd450;
        tick();
        checks++; if (collision !== 1'b0) begin errors++; $display("FAIL catch_pulse_end: got %0d want 0", collision); end
        tick();
        checks++; if (score !== 16'd1) begin errors++; $display("FAIL catch_disarmed_score: got %0d want 1", score); end
    endtask

    task automatic test_miss_over();
        apply_reset();
        drop(10'd110, 10'd300, 2'd1);
        checks++; if (collision !== 1'b0) begin errors++; $display("FAIL miss1_collision: got %0d want 0", collision); end
        checks++; if (misses !== 2'd1) begin errors++; $display("FAIL miss1_count: got %0d want 1", misses); end
        // Below MISS_Y and not touching the tower: no decision yet
        item_y = 10'd0;   tick();
        item_y = 10'd399; tick();
        checks++; if (misses !== 2'd1) begin errors++; $display("FAIL miss_y399: got %0d want 1", misses); end
        item_y = 10'd400; tick();
        checks++; if (misses !== 2'd2) begin errors++; $display("FAIL miss_y400: got %0d want 2", misses); end
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL miss2_over: got %0d want 0", game_over); end
        drop(10'd110, 10'd300, 2'd1);
        checks++; if (misses !== 2'd3) begin errors++; $display("FAIL miss3_count: got %0d want 3", misses); end
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL miss3_over: got %0d want 1", game_over); end
        drop(10'd110, 10'd100, 2'd2);
        checks++; if (collision !== 1'b0) begin errors++; $display("FAIL over_collision: got %0d want 0", collision); end
        checks++; if (score !== 16'd0) begin errors++; $display("FAIL over_score: got %0d want 0", score); end
        checks++; if (stack_height !== 4'd0) begin errors++; $display("FAIL over_height: got %0d want 0", stack_height); end
        checks++; if (misses !== 2'd3) begin errors++; $display("FAIL over_misses: got %0d want 3", misses); end
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL over_sticky: got %0d want 1", game_over); end
    endtask

    task automatic test_overlap_edges();
        logic [9:0] xs [4];
        logic       hit [4];
        xs  = '{10'd80, 10'd81, 10'd179, 10'd180};
        hit = '{1'b0, 1'b1, 1'b1, 1'b0};
        apply_reset();
        foreach (xs[i]) begin
            drop(xs[i], 10'd100, 2'd3);
            checks++; if (collision !== hit[i]) begin errors++; $display("FAIL edge_x%0d: got %0d want %0d", xs[i], collision, hit[i]); end
        end
        checks++; if (stack_height !== 4'd2) begin errors++; $display("FAIL edge_height: got %0d want 2", stack_height); end
        checks++; if (score !== 16'd2) begin errors++; $display("FAIL edge_score: got %0d want 2", score); end
        checks++; if (misses !== 2'd2) begin errors++; $display("FAIL edge_misses: got %0d want 2", misses); end
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL edge_over: got %0d want 0", game_over); end
    endtask

    task automatic test_clear();
        apply_reset();
        for (int k = 1; k <= 8; k++) begin
            drop(10'd110, 10'd100, (k % 2 == 1) ? 2'd1 : 2'd2);
            checks++; if (stack_height !== 4'(k)) begin errors++; $display("FAIL fill_height%0d: got %0d want %0d", k, stack_height, k); end
        end
        checks++; if (collision !== 1'b1) begin errors++; $display("FAIL fill_pulse: got %0d want 1", collision); end
        checks++; if (score !== 16'd8) begin errors++; $display("FAIL fill_score: got %0d want 8", score); end
        checks++; if (stack_colors !== 16'h9999) begin errors++; $display("FAIL fill_colors: got %h want 9999", stack_colors); end
        item_y = 10'd450;
        tick();
        checks++; if (stack_height !== 4'd0) begin errors++; $display("FAIL clear_height: got %0d want 0", stack_height); end
        checks++; if (score !== 16'd24) begin errors++; $display("FAIL clear_score: got %0d want 24", score); end
        checks++; if (stack_colors !== 16'h0) begin errors++; $display("FAIL clear_colors: got %h want 0000", stack_colors); end
        checks++; if (collision !== 1'b0) begin errors++; $display("FAIL clear_collision: got %0d want 0", collision); end
        tick();
        drop(10'd110, 10'd100, 2'd3);
        checks++; if (stack_height !== 4'd1) begin errors++; $display("FAIL after_clear_height: got %0d want 1", stack_height); end
        checks++; if (score !== 16'd25) begin errors++; $display("FAIL after_clear_score: got %0d want 25", score); end
    endtask

    task automatic test_pause();
        apply_reset();
        item_x = 10'd110; catcher_x = 10'd100; item_color = 2'd2;
        item_y = 10'd0; tick();
        pause = 1'b1; item_y = 10'd440; tick();
        checks++; if (collision !== 1'b0) begin errors++; $display("FAIL pause_hold1: got %0d want 0", collision); end
        tick();
        checks++; if (score !== 16'd0) begin errors++; $display("FAIL pause_score: got %0d want 0", score); end
        pause = 1'b0; tick();
        checks++; if (collision !== 1'b1) begin errors++; $display("FAIL unpause_catch: got %0d want 1", collision); end
        checks++; if (score !== 16'd1) begin errors++; $display("FAIL unpause_score: got %0d want 1", score); end
        pause = 1'b1; tick();
        checks++; if (collision !== 1'b0) begin errors++; $display("FAIL pause_catch_done: got %0d want 0", collision); end
        pause = 1'b0;
    endtask

    task automatic test_rst_mid_catch();
        apply_reset();
        drop(10'd110, 10'd100, 2'd1);
        checks++; if (collision !== 1'b1) begin errors++; $display("FAIL pre_rst_pulse: got %0d want 1", collision); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (collision !== 1'b0) begin errors++; $display("FAIL rst_collision: got %0d want 0", collision); end
        checks++; if (score !== 16'd0) begin errors++; $display("FAIL rst_score: got %0d want 0", score); end
        checks++; if (stack_height !== 4'd0) begin errors++; $display("FAIL rst_height: got %0d want 0", stack_height); end
        #1;
        rst = 1'b0;
    endtask

    task automatic test_color_match();
        logic [3:0]  exp_h [3];
        logic [15:0] exp_s [3];
`ifdef SKY_STACKER_COLOR_MATCH_EN
        exp_h = '{4'd1, 4'd2, 4'd0};
        exp_s = '{16'd1, 16'd2, 16'd7};
`else
        exp_h = '{4'd1, 4'd2, 4'd3};
        exp_s = '{16'd1, 16'd2, 16'd3};
`endif
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            drop(10'd110, 10'd100, 2'd2);
            checks++; if (collision !== 1'b1) begin errors++; $display("FAIL match_pulse%0d: got %0d want 1", k, collision); end
            checks++; if (stack_height !== exp_h[k]) begin errors++; $display("FAIL match_height%0d: got %0d want %0d", k, stack_height, exp_h[k]); end
            checks++; if (score !== exp_s[k]) begin errors++; $display("FAIL match_score%0d: got %0d want %0d", k, score, exp_s[k]); end
        end
    endtask

    initial begin
        rst        = 1'b0;
        pause      = 1'b0;
        item_x     = 10'd0;
        item_y     = 10'd100;
        item_color = 2'd1;
        catcher_x  = 10'd0;
        #1;
        test_reset();
        test_catch();
        test_miss_over();
        test_overlap_edges();
        test_clear();
        test_pause();
        test_rst_mid_catch();
        test_color_match();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
